// File: rtl/sr_ctrl.sv
// ============================================================================
// Module  : sr_ctrl
// Brief   : Status register (R2/SR) owner, update arbiter and interrupt-entry
//           SR push sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_ctrl #(
    parameter logic [15:0] RESET_SR  = 16'h0000,
    parameter bit          KEEP_SCG0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_we,
    input  logic        flag_c,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_v,
    input  logic        sw_we,
    input  logic [15:0] sw_data,
    input  logic        reti_valid,
    input  logic [15:0] reti_data,
    input  logic        irq_ack,
    input  logic        push_ready,
    output logic [15:0] sr,
    output logic        gie,
    output logic        cpu_off,
    output logic        osc_off,
    output logic        scg0,
    output logic        scg1,
    output logic        push_valid,
    output logic [15:0] push_data,
    output logic        irq_done,
    output logic        busy
);

    localparam logic [15:0] c_sr_mask    = 16'h01FF;
    localparam logic [15:0] c_flag_mask  = 16'h0107;
    localparam logic [15:0] c_clear_mask = KEEP_SCG0 ? 16'h0040 : 16'h0000;
    localparam logic [15:0] c_reset_sr   = RESET_SR & c_sr_mask;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PUSH  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_sr;
    logic [15:0] w_sr_next;
    logic [15:0] r_push_data;
    logic        w_load_push;
    logic [15:0] w_flag_bits;

    assign w_flag_bits = {7'b0, flag_v, 5'b0, flag_n, flag_z, flag_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sr        <= c_reset_sr;
            r_push_data <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_sr    <= w_sr_next;
            if (w_load_push) begin
                r_push_data <= w_sr_next;
            end
        end
    end

    // Only IDLE accepts SR writes; the pushed snapshot is the post-write value
    // so a RETI restore coinciding with irq_ack is what gets stacked.
    always_comb begin
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_load_push  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reti_valid) begin
                    w_sr_next = reti_data & c_sr_mask;
                end else if (sw_we && flag_we) begin
                    w_sr_next = (sw_data & c_sr_mask & ~c_flag_mask) | w_flag_bits;
                end else if (sw_we) begin
                    w_sr_next = sw_data & c_sr_mask;
                end else if (flag_we) begin
                    w_sr_next = (r_sr & ~c_flag_mask) | w_flag_bits;
                end
                if (irq_ack) begin
                    w_state_next = ST_PUSH;
                    w_load_push  = 1'b1;
                end
            end
            ST_PUSH: begin
                if (push_ready) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_sr_next    = r_sr & c_clear_mask;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign sr         = r_sr;
    assign gie        = r_sr[3];
    assign cpu_off    = r_sr[4];
    assign osc_off    = r_sr[5];
    assign scg0       = r_sr[6];
    assign scg1       = r_sr[7];
    assign push_valid = (r_state == ST_PUSH);
    assign push_data  = r_push_data;
    assign irq_done   = (r_state == ST_CLEAR);
    assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sr_ctrl.sv
// ============================================================================
// Module  : tb_sr_ctrl
// Brief   : Directed self-checking bench for sr_ctrl (two instances differing
//           only in KEEP_SCG0).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flag_we, flag_c, flag_z, flag_n, flag_v;
    logic        sw_we;
    logic [15:0] sw_data;
    logic        reti_valid;
    logic [15:0] reti_data;
    logic        irq_ack;
    logic        push_ready;

    logic [15:0] sr_a, push_data_a;
    logic        gie_a, cpu_off_a, osc_off_a, scg0_a, scg1_a;
    logic        push_valid_a, irq_done_a, busy_a;
    logic [15:0] sr_b, push_data_b;
    logic        gie_b, cpu_off_b, osc_off_b, scg0_b, scg1_b;
    logic        push_valid_b, irq_done_b, busy_b;

    int total = 0;
    int bad   = 0;

    sr_ctrl #(.RESET_SR(16'hFFFF), .KEEP_SCG0(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .flag_we(flag_we), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .sw_we(sw_we), .sw_data(sw_data),
        .reti_valid(reti_valid), .reti_data(reti_data),
        .irq_ack(irq_ack), .push_ready(push_ready),
        .sr(sr_a), .gie(gie_a), .cpu_off(cpu_off_a), .osc_off(osc_off_a),
        .scg0(scg0_a), .scg1(scg1_a),
        .push_valid(push_valid_a), .push_data(push_data_a),
        .irq_done(irq_done_a), .busy(busy_a)
    );

    sr_ctrl #(.RESET_SR(16'hFFFF), .KEEP_SCG0(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .flag_we(flag_we), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .sw_we(sw_we), .sw_data(sw_data),
        .reti_valid(reti_valid), .reti_data(reti_data),
        .irq_ack(irq_ack), .push_ready(push_ready),
        .sr(sr_b), .gie(gie_b), .cpu_off(cpu_off_b), .osc_off(osc_off_b),
        .scg0(scg0_b), .scg1(scg1_b),
        .push_valid(push_valid_b), .push_data(push_data_b),
        .irq_done(irq_done_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flag_we = 0; flag_c = 0; flag_z = 0; flag_n = 0; flag_v = 0;
        sw_we = 0; sw_data = 16'h0000;
        reti_valid = 0; reti_data = 16'h0000;
        irq_ack = 0; push_ready = 0;
    endtask

    task automatic set_sr(input logic [15:0] v);
        sw_we = 1; sw_data = v;
        step();
        sw_we = 0; sw_data = 16'h0000;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        step();
        total++;
        if (sr_a !== 16'h01FF) begin bad++; $display("FAIL reset_sr: got %h want %h", sr_a, 16'h01FF); end
        total++;
        if ({busy_a, push_valid_a, irq_done_a} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl: busy/pv/done got %b want 000", {busy_a, push_valid_a, irq_done_a});
        end
        total++;
        if (push_data_a !== 16'h0000) begin bad++; $display("FAIL reset_push_data: got %h want 0000", push_data_a); end
        total++;
        if ({scg1_a, scg0_a, osc_off_a, cpu_off_a, gie_a} !== 5'b11111) begin
            bad++; $display("FAIL reset_decode: got %b want 11111", {scg1_a, scg0_a, osc_off_a, cpu_off_a, gie_a});
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        total++;
        if (sr_a !== 16'h01FF) begin bad++; $display("FAIL reset_hold: got %h want %h", sr_a, 16'h01FF); end
    endtask

    task automatic test_writes();
        set_sr(16'h0008);
        flag_we = 1; flag_c = 1; flag_z = 0; flag_n = 1; flag_v = 1;
        step();
        flag_we = 0;
        total++;
        if (sr_a !== 16'h010D) begin bad++; $display("FAIL flag_only: got %h want %h", sr_a, 16'h010D); end

        set_sr(16'h0008);
        flag_we = 1; sw_we = 1; sw_data = 16'h0010;
        step();
        flag_we = 0; sw_we = 0;
        total++;
        if (sr_a !== 16'h0115) begin bad++; $display("FAIL flag_sw_merge: got %h want %h", sr_a, 16'h0115); end

        set_sr(16'hFFFF);
        total++;
        if (sr_a !== 16'h01FF) begin bad++; $display("FAIL sw_reserved: got %h want %h", sr_a, 16'h01FF); end

        flag_we = 1; flag_c = 0; flag_z = 0; flag_n = 0; flag_v = 0;
        step();
        flag_we = 0;
        total++;
        if (sr_a !== 16'h00F8) begin bad++; $display("FAIL flag_hold_others: got %h want %h", sr_a, 16'h00F8); end

        reti_valid = 1; reti_data = 16'h8003;
        sw_we = 1; sw_data = 16'h0150; flag_we = 1; flag_z = 1;
        step();
        clear_inputs();
        total++;
        if (sr_a !== 16'h0003) begin bad++; $display("FAIL reti_priority: got %h want %h", sr_a, 16'h0003); end
    endtask

    task automatic test_irq_entry();
        set_sr(16'h0158);
        irq_ack = 1;
        step();
        irq_ack = 0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (push_valid_a !== 1'b1 || push_data_a !== 16'h0158 || busy_a !== 1'b1) begin
                bad++; $display("FAIL push_cycle%0d: pv=%b data=%h busy=%b want 1 0158 1", i, push_valid_a, push_data_a, busy_a);
            end
            total++;
            if (irq_done_a !== 1'b0 || sr_a !== 16'h0158) begin
                bad++; $display("FAIL push_hold%0d: done=%b sr=%h want 0 0158", i, irq_done_a, sr_a);
            end
            push_ready = (i == 3);
            step();
        end
        push_ready = 0;
        total++;
        if (irq_done_a !== 1'b1 || push_valid_a !== 1'b0 || busy_a !== 1'b1) begin
            bad++; $display("FAIL clear_cycle: done=%b pv=%b busy=%b want 1 0 1", irq_done_a, push_valid_a, busy_a);
        end
        step();
        total++;
        if (sr_a !== 16'h0040 || gie_a !== 1'b0 || scg0_a !== 1'b1) begin
            bad++; $display("FAIL keep_scg0_sr: sr=%h gie=%b scg0=%b want 0040 0 1", sr_a, gie_a, scg0_a);
        end
        total++;
        if (sr_b !== 16'h0000) begin bad++; $display("FAIL drop_scg0_sr: got %h want 0000", sr_b); end
        total++;
        if (busy_a !== 1'b0 || irq_done_a !== 1'b0) begin
            bad++; $display("FAIL entry_idle: busy=%b done=%b want 0 0", busy_a, irq_done_a);
        end
    endtask

    task automatic test_busy_ignore();
        int done_cnt;
        done_cnt = 0;
        set_sr(16'h0158);
        irq_ack = 1;
        step();
        sw_we = 1; sw_data = 16'hFFFF; reti_valid = 1; reti_data = 16'h01FF;
        flag_we = 1; flag_c = 1;
        for (int i = 0; i < 3; i++) begin
            if (irq_done_a === 1'b1) done_cnt++;
            total++;
            if (sr_a !== 16'h0158 || push_data_a !== 16'h0158) begin
                bad++; $display("FAIL busy_ignore%0d: sr=%h data=%h want 0158 0158", i, sr_a, push_data_a);
            end
            push_ready = (i == 2);
            step();
        end
        push_ready = 0;
        if (irq_done_a === 1'b1) done_cnt++;
        total++;
        if (sr_a !== 16'h0158) begin bad++; $display("FAIL busy_clear_sr: got %h want 0158", sr_a); end
        step();
        clear_inputs();
        total++;
        if (sr_a !== 16'h0040 || busy_a !== 1'b0) begin
            bad++; $display("FAIL busy_final: sr=%h busy=%b want 0040 0", sr_a, busy_a);
        end
        for (int i = 0; i < 3; i++) begin
            if (irq_done_a === 1'b1) done_cnt++;
            step();
        end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL irq_done_count: got %0d want 1", done_cnt); end
        total++;
        if (push_valid_a !== 1'b0 || sr_a !== 16'h0040) begin
            bad++; $display("FAIL second_ack_ignored: pv=%b sr=%h want 0 0040", push_valid_a, sr_a);
        end
    endtask

    task automatic test_back_to_back();
        reti_valid = 1; reti_data = 16'hFE18; irq_ack = 1;
        step();
        clear_inputs();
        total++;
        if (push_data_a !== 16'h0018 || push_valid_a !== 1'b1) begin
            bad++; $display("FAIL reti_ack_push: data=%h pv=%b want 0018 1", push_data_a, push_valid_a);
        end
        total++;
        if (sr_a !== 16'h0018) begin bad++; $display("FAIL reti_ack_sr: got %h want 0018", sr_a); end
    endtask

    task automatic test_reset_mid_push();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (push_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL async_abort: pv=%b busy=%b want 0 0", push_valid_a, busy_a);
        end
        total++;
        if (sr_a !== 16'h01FF || push_data_a !== 16'h0000) begin
            bad++; $display("FAIL async_abort_sr: sr=%h data=%h want 01FF 0000", sr_a, push_data_a);
        end
        push_ready = 1;
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (irq_done_a !== 1'b0 || push_valid_a !== 1'b0 || sr_a !== 16'h01FF) begin
            bad++; $display("FAIL post_abort: done=%b pv=%b sr=%h want 0 0 01FF", irq_done_a, push_valid_a, sr_a);
        end
        push_ready = 0;
    endtask

    initial begin
        test_reset();
        test_writes();
        test_irq_entry();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_push();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
